// File: rtl/kf_pkg.sv
// kf_pkg: shared state encoding and default widths for the Kalman filter host loader.
package kf_pkg;
  localparam int W_DEF = 24;
  localparam int ADDRW_DEF = 5;
  localparam int FRAC = 14;
  typedef enum logic [2:0] {IDLE, LOAD, KICK, WBUSY, WDONE, OUT} state_t;
endpackage

// File: rtl/kf_tmo_cnt.sv
// kf_tmo_cnt: loadable down-counter that flags done when it has run down to zero.
module kf_tmo_cnt #(
  parameter int N = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);
  localparam int CW = $clog2(N + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || load) cnt <= CW'(N);
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign done = cnt == '0;
endmodule

// File: rtl/kf_host_loader.sv
// kf_host_loader: streams measurement words into the core data bank, kicks one iteration and returns DATA_OUT.
module kf_host_loader
  import kf_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int ADDRW = ADDRW_DEF,
  parameter int NMEAS = 2,
  parameter int MEAS_BASE = 0,
  parameter int TMO_CYC = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [W-1:0]     kf_data_in,
  output logic [ADDRW-1:0] kf_dir,
  output logic             kf_write,
  output logic             kf_start,
  input  logic             kf_ready,
  input  logic [W-1:0]     kf_data_out,
  output logic [15:0]      iter_cnt,
  output logic             tmo_err
);
  localparam int IW = ADDRW + 1;
  localparam logic [ADDRW-1:0] BASE = ADDRW'(MEAS_BASE);
  localparam logic [IW-1:0] LAST = IW'(NMEAS - 1);
  state_t state;
  logic [IW-1:0] idx;
  logic tmo;
  logic in_fire;
  assign in_fire = in_valid && in_ready;
  // watchdog reloads on entry to each READY-wait state
  kf_tmo_cnt #(.N(TMO_CYC)) u_tmo (
    .clk (clk),
    .rst (rst),
    .load(state == KICK || (state == WBUSY && !kf_ready)),
    .en  (state == WBUSY || state == WDONE),
    .done(tmo)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      kf_data_in <= '0;
      kf_dir     <= BASE;
      kf_write   <= 1'b0;
      kf_start   <= 1'b0;
      iter_cnt   <= '0;
      tmo_err    <= 1'b0;
    end else begin
      kf_write <= 1'b0;
      kf_start <= 1'b0;
      case (state)
        IDLE: if (kf_ready) begin
          state    <= LOAD;
          idx      <= '0;
          in_ready <= 1'b1;
        end
        LOAD: if (in_fire) begin
          kf_write   <= 1'b1;
          kf_dir     <= BASE + idx[ADDRW-1:0];
          kf_data_in <= in_data;
          idx        <= idx + 1'b1;
          if (idx == LAST) begin
            in_ready <= 1'b0;
            state    <= KICK;
          end
        end
        KICK: begin
          kf_start <= 1'b1;
          state    <= WBUSY;
        end
        WBUSY: if (!kf_ready) state <= WDONE;
        else if (tmo) begin
          tmo_err   <= 1'b1;
          out_data  <= kf_data_out;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        WDONE: if (kf_ready) begin
          out_data  <= kf_data_out;
          out_valid <= 1'b1;
          iter_cnt  <= iter_cnt + 1'b1;
          state     <= OUT;
        end else if (tmo) begin
          tmo_err   <= 1'b1;
          out_data  <= kf_data_out;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kf_host_loader.sv
// tb_kf_host_loader: scoreboard bench with a behavioural core; base address 31 exercises bank wrap.
module tb_kf_host_loader;
  localparam int W = 24;
  localparam int ADDRW = 5;
  localparam int NMEAS = 2;
  localparam int BASE = 31;
  localparam int TMO = 40;
  typedef struct packed {
    logic [W-1:0] d;
    logic [15:0]  it;
    logic         t;
  } out_t;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, kf_write, kf_start, kf_ready, tmo_err;
  logic [W-1:0] in_data, out_data, kf_data_in, kf_data_out, core_result;
  logic [ADDRW-1:0] kf_dir, d0, d1;
  logic [15:0] iter_cnt;
  logic [ADDRW+W-1:0] exp_w[$];
  out_t exp_o[$];
  int starts_exp, checks, errors, core_mode;
  logic prev_w, prev_s;
  kf_host_loader #(.W(W), .ADDRW(ADDRW), .NMEAS(NMEAS), .MEAS_BASE(BASE), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .kf_data_in(kf_data_in), .kf_dir(kf_dir), .kf_write(kf_write), .kf_start(kf_start),
    .kf_ready(kf_ready), .kf_data_out(kf_data_out), .iter_cnt(iter_cnt), .tmo_err(tmo_err)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  // core model: mode 0 runs 30 cycles, 1 never drops READY, 2 drops READY and stalls
  initial begin
    kf_ready = 1;
    kf_data_out = '0;
    forever begin
      @(posedge clk); #1;
      if (kf_start) begin
        if (core_mode == 0) begin
          kf_ready = 0;
          repeat (30) @(posedge clk);
          #1;
          kf_data_out = core_result;
          kf_ready = 1;
        end else if (core_mode == 1) kf_data_out = core_result;
        else begin
          kf_ready = 0;
          kf_data_out = core_result;
          wait (core_mode != 2);
          @(posedge clk); #1;
          kf_ready = 1;
        end
      end
    end
  end
  initial begin
    out_t e;
    logic [ADDRW+W-1:0] w;
    prev_w = 0;
    prev_s = 0;
    forever begin
      @(negedge clk);
      if (kf_write) begin
        if (exp_w.size() == 0) chk("unexpected_write", {8'b0, kf_data_in}, 32'hFFFFFFFF);
        else begin
          w = exp_w.pop_front();
          chk("write_dir", 32'(kf_dir), 32'(w[ADDRW+W-1:W]));
          chk("write_data", 32'(kf_data_in), 32'(w[W-1:0]));
        end
      end
      if (kf_start) begin
        chk("start_write_low", 32'(kf_write), 0);
        chk("start_after_write", 32'(prev_w), 1);
        chk("start_one_cycle", 32'(prev_s), 0);
        chk("start_expected", 32'(starts_exp > 0), 1);
        if (starts_exp > 0) starts_exp--;
      end
      if (out_valid && out_ready) begin
        if (exp_o.size() == 0) chk("unexpected_out", 32'(out_data), 32'hFFFFFFFF);
        else begin
          e = exp_o.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_iter", 32'(iter_cnt), 32'(e.it));
          chk("out_tmo", 32'(tmo_err), 32'(e.t));
        end
      end
      prev_w = kf_write;
      prev_s = kf_start;
    end
  end
  task automatic send(input logic [W-1:0] v, input logic [ADDRW-1:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1;
    in_data = v;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_timeout", 32'(in_ready), 1);
    exp_w.push_back({d, v});
    if (last) starts_exp++;
    @(posedge clk); #1;
    in_valid = 0;
    chk("write_now", 32'({kf_write, kf_dir}), 32'({1'b1, d}));
  endtask
  task automatic load2(input logic [W-1:0] a, input logic [W-1:0] b);
    send(a, d0, 0);
    send(b, d1, 1);
  endtask
  task automatic wait_out(input int budget);
    int n;
    n = 0;
    while (exp_o.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("out_timeout", 32'(exp_o.size()), 0);
    exp_o.delete();
    @(posedge clk); #1;
  endtask
  task automatic wait_sig(input string name, input int which);
    int n;
    n = 0;
    while (!(which == 0 ? in_ready : which == 1 ? out_valid : kf_start) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(which == 0 ? in_ready : which == 1 ? out_valid : kf_start), 1);
  endtask
  initial begin
    int n;
    checks = 0;
    errors = 0;
    starts_exp = 0;
    core_mode = 0;
    core_result = '0;
    d0 = ADDRW'(BASE);
    d1 = d0 + 1'b1;
    rst = 1;
    in_valid = 0;
    in_data = '0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_kf_write", 32'(kf_write), 0);
    chk("rst_kf_start", 32'(kf_start), 0);
    chk("rst_tmo_err", 32'(tmo_err), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_kf_data_in", 32'(kf_data_in), 0);
    chk("rst_kf_dir", 32'(kf_dir), BASE);
    chk("rst_iter_cnt", 32'(iter_cnt), 0);
    rst = 0;
    core_result = 24'h006000;
    exp_o.push_back('{24'h006000, 16'd1, 1'b0});
    load2(24'h004000, 24'h002000);
    wait_out(200);
    chk("iter1_cnt", 32'(iter_cnt), 1);
    out_ready = 0;
    core_result = 24'h00ABCD;
    exp_o.push_back('{24'h00ABCD, 16'd2, 1'b0});
    load2(24'h001111, 24'h002222);
    wait_sig("bp_out_valid_wait", 1);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_data", 32'(out_data), 32'h00ABCD);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1;
    wait_out(20);
    wait_sig("iter3_in_ready", 0);
    core_mode = 1;
    core_result = 24'h123456;
    exp_o.push_back('{24'h123456, 16'd2, 1'b1});
    load2(24'h003333, 24'h004444);
    wait_sig("tmo_start_wait", 2);
    n = 0;
    while (!tmo_err && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tmo_busy_cycles", 32'(n), TMO + 1);
    chk("tmo_busy_out_valid", 32'(out_valid), 1);
    wait_out(20);
    core_mode = 2;
    core_result = 24'h0F0F0F;
    exp_o.push_back('{24'h0F0F0F, 16'd2, 1'b1});
    load2(24'h005555, 24'h006666);
    wait_out(200);
    repeat (20) begin
      @(posedge clk); #1;
      chk("idle_ready_low_in_ready", 32'(in_ready), 0);
    end
    chk("tmo_iter_unchanged", 32'(iter_cnt), 2);
    core_mode = 0;
    wait_sig("post_tmo_in_ready", 0);
    send(24'hAAAAAA, d0, 0);
    rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_kf_write", 32'(kf_write), 0);
    chk("mid_rst_kf_start", 32'(kf_start), 0);
    chk("mid_rst_kf_dir", 32'(kf_dir), BASE);
    chk("mid_rst_tmo_err", 32'(tmo_err), 0);
    chk("mid_rst_iter", 32'(iter_cnt), 0);
    rst = 0;
    chk("mid_rst_write_queue", 32'(exp_w.size()), 0);
    core_result = 24'h000777;
    exp_o.push_back('{24'h000777, 16'd1, 1'b0});
    load2(24'h007777, 24'h008888);
    wait_out(200);
    chk("final_iter", 32'(iter_cnt), 1);
    chk("final_writes_left", 32'(exp_w.size()), 0);
    chk("final_starts_left", 32'(starts_exp), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
